// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic OV5640-style DVP source (vsync/href/RGB565 bytes) with bars, ramp and solid patterns.
// Build option DVP_TX_FRAME_TAG_EN stamps pixel (0,0) of every frame with {8'hA5, frame_cnt}.
module dvp_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 8
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic [1:0]  I_pattern,
  input  logic [15:0] I_solid,
  output logic        O_vsync,
  output logic        O_href,
  output logic [7:0]  O_data,
  output logic        O_busy,
  output logic        O_frame_done
);

  // state    | meaning
  // S_IDLE   | waiting for I_en, counters held at 0
  // S_VSYNC  | V_SYNC lines with vsync high
  // S_VBP    | V_BP quiet lines before the first active line
  // S_ACTIVE | V_ACTIVE lines, href over the first 2*H_ACTIVE clocks
  // S_VFP    | V_FP quiet lines; last clock ends the frame
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int VMAX     = (V_ACTIVE > V_SYNC && V_ACTIVE > V_BP && V_ACTIVE > V_FP) ? V_ACTIVE :
                            (V_SYNC > V_BP && V_SYNC > V_FP) ? V_SYNC :
                            (V_BP > V_FP) ? V_BP : V_FP;
  localparam int VW       = $clog2(VMAX + 1);
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HACT2     = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] VSYNC_M1  = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VBP_M1    = VW'(V_BP - 1);
  localparam logic [VW-1:0] VACT_M1   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VFP_M1    = VW'(V_FP - 1);
  localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [BW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [1:0]      pat_q, pat_d;
  logic [15:0]     solid_q, solid_d;
  logic            vsync_q, href_q, busy_q, done_q;
  logic [7:0]      data_q;

  logic            vsync_d, href_d, busy_d, done_d;
  logic [7:0]      data_d;
  logic            latch_cfg, line_last;
  logic [VW-1:0]   lines_m1;
  logic [5:0]      x6;
  logic [15:0]     bar_pix, pix;

`ifdef DVP_TX_FRAME_TAG_EN
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            x_zero;
`endif

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    latch_cfg = 1'b0;
    line_last = (h_cnt_q == H_LAST);
    case (state_q)
      S_VSYNC:  lines_m1 = VSYNC_M1;
      S_VBP:    lines_m1 = VBP_M1;
      S_ACTIVE: lines_m1 = VACT_M1;
      S_VFP:    lines_m1 = VFP_M1;
      default:  lines_m1 = '0;
    endcase
    done_d = (state_q == S_VFP) && line_last && (v_cnt_q == lines_m1);

    if (state_q == S_IDLE) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (I_en) begin
        state_d   = S_VSYNC;
        latch_cfg = 1'b1;
      end
    end else begin
      h_cnt_d = line_last ? '0 : h_cnt_q + 1'b1;
      if (line_last) begin
        if (v_cnt_q == lines_m1) begin
          v_cnt_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBP;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFP;
            default: begin
              state_d   = I_en ? S_VSYNC : S_IDLE;
              latch_cfg = I_en;
            end
          endcase
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end
    end

    pat_d   = pat_q;
    solid_d = solid_q;
    if (latch_cfg) begin
      pat_d   = (I_pattern == 2'd3) ? 2'd0 : I_pattern;
      solid_d = I_solid;
    end
  end

  // Bar position advances after the low byte of each pixel, so no divide by BAR_W is needed.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    href_d    = (state_q == S_ACTIVE) && (h_cnt_q < HACT2);
    if (state_q != S_ACTIVE || line_last) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (href_d && h_cnt_q[0]) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  always_comb begin
    x6 = 6'(h_cnt_q >> 1);
    case (bar_idx_q)
      3'd0:    bar_pix = 16'hFFFF;
      3'd1:    bar_pix = 16'hFFE0;
      3'd2:    bar_pix = 16'h07FF;
      3'd3:    bar_pix = 16'h07E0;
      3'd4:    bar_pix = 16'hF81F;
      3'd5:    bar_pix = 16'hF800;
      3'd6:    bar_pix = 16'h001F;
      default: bar_pix = 16'h0000;
    endcase
    case (pat_q)
      2'd1:    pix = {x6[4:0], x6, x6[4:0]};
      2'd2:    pix = solid_q;
      default: pix = bar_pix;
    endcase
`ifdef DVP_TX_FRAME_TAG_EN
    x_zero      = (h_cnt_q[HW-1:1] == '0);
    frame_cnt_d = done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    if (state_q == S_ACTIVE && v_cnt_q == '0 && x_zero)
      pix = {8'hA5, frame_cnt_q};
`endif
    vsync_d = (state_q == S_VSYNC);
    busy_d  = (state_q != S_IDLE);
    data_d  = href_d ? (h_cnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      solid_q   <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DVP_TX_FRAME_TAG_EN
      frame_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DVP_TX_FRAME_TAG_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign O_vsync      = vsync_q;
  assign O_href       = href_q;
  assign O_data       = data_q;
  assign O_busy       = busy_q;
  assign O_frame_done = done_q;

endmodule
